fp_align: RTL
=============

// Module: fp_align
// PURPOSE
// Pre-add operand alignment stage of the FP adder; the inverse of the post-add normalizer. Takes
// two packed FP operands and orders them by magnitude. Right-shifts the smaller mantissa (with
// hidden bit) by the exponent difference and emits both mantissas on a common exponent, ready for
// the adder. The adder then produces the (MANT_W+2)-bit sum consumed by normalization.
// Two-stage pipeline with valid/ready handshake on both sides.
// PARAMETERS
// EXP_W   4  exponent width (biased, unsigned); exp==0 encodes zero
// MANT_W  4  stored fraction width (hidden bit not stored)
// PORTS
// clk             in   1         clock, all state on rising edge
// rst             in   1         synchronous reset, active-high
// in_valid        in   1         input operand pair valid
// in_ready        out  1         block accepts pair this cycle
// in_sign_a/b     in   1         operand signs
// in_exp_a/b      in   EXP_W     operand exponents
// in_mant_a/b     in   MANT_W    operand fractions
// out_valid       out  1         aligned result valid
// out_ready       in   1         downstream accepts result
// out_sign_big    out  1         sign of larger-magnitude operand
// out_sign_small  out  1         sign of smaller-magnitude operand
// out_exp         out  EXP_W     common exponent (= larger exponent)
// out_mant_big    out  MANT_W+1  {hidden,frac} of larger operand, unshifted
// out_mant_small  out  MANT_W+1  {hidden,frac} of smaller operand, shifted right by diff
// out_sticky      out  1         OR of all bits shifted out of the small mantissa
// out_swapped     out  1         1 when operand B was the larger
// out_eff_sub     out  1         in_sign_a XOR in_sign_b (effective subtraction)
// BEHAVIOUR
// - Reset: out_valid=0, both stage valids=0, all data outputs 0; in_ready=1 on the cycle after rst.
// - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
// - Stage 1 (compare), on accept: extend each operand to {hidden,frac}. hidden=1 if exp!=0.
//   - exp==0: the whole MANT_W+1 mantissa is forced to 0.
//   - big = A if exp_a>exp_b, or (exp_a==exp_b and mant_a>=mant_b); otherwise B (swapped=1).
//   - Register big/small fields, diff=exp_big-exp_small (EXP_W bits, unsigned), swapped, eff_sub.
// - Stage 2 (shift): mant_small_out = mant_small >> diff.
//   - diff > MANT_W+1: mant_small_out=0 and sticky = |mant_small.
//   - otherwise sticky = OR of the diff low bits shifted out; diff=0 gives sticky=0.
//   - out_exp=exp_big; out_mant_big is passed through unshifted.
// - Latency 2 cycles accept-to-out_valid; throughput 1 pair/cycle when out_ready=1.
// - Flow control: s2 loads when !s2_valid | out_ready; s1 advances under the same condition.
//   - in_ready = !s1_valid | (!s2_valid | out_ready); in_ready is combinational from out_ready.
//   - No bubbles are inserted when both stages are full and out_ready=1.
// - Stall (out_valid & !out_ready): all out_* held bit-stable; at most 2 pairs buffered; no loss or
//   reordering.
// - Simultaneous accept and emit in the same cycle is legal and required.
// - rst mid-operation: both stages are flushed; in-flight pairs are discarded, never emitted.
// - Result ordering is strictly FIFO.
// TESTING
// 1. A=(0,5,1000) B=(0,3,0100) -> 2 cyc later: exp=5 big=11000 small=00101 sticky=0 swapped=0
//    eff_sub=0
// 2. A=(1,2,0000) B=(0,6,1111) -> exp=6 big=11111 small=00001 sticky=0 swapped=1 eff_sub=1
//    sign_big=0
// 3. A=(0,12,0000) B=(0,1,0001), diff=11 -> small=00000 sticky=1 exp=12; B=(0,10,0011) A=(0,8,0001):
//    small=00100 sticky=1
// 4. A=(0,4,0010) B=(0,4,0110) -> swapped=1 big=10110 small=10010 sticky=0; B exp=0 mant=1010
//    -> small=00000 sticky=0
// 5. Stream 5 pairs with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepted; outputs stable;
//    all 5 emerge in order after release
// 6. Assert rst with 2 pairs in flight -> out_valid=0 next cycle; no stale result emitted; next
//    pair emerges after 2 cycles

Source files
------------

// File: rtl/fp_align.sv
// rtl/fp_align.sv - pre-add operand alignment: magnitude compare, swap, right-shift with sticky
module fp_align #(
    parameter int EXP_W  = 4,
    parameter int MANT_W = 4
) (
    input  logic              clk,
    input  logic              rst,            // synchronous, active-high
    // operand pair in
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic [EXP_W-1:0]  in_exp_a,
    input  logic [EXP_W-1:0]  in_exp_b,
    input  logic [MANT_W-1:0] in_mant_a,
    input  logic [MANT_W-1:0] in_mant_b,
    // aligned pair out
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign_big,
    output logic              out_sign_small,
    output logic [EXP_W-1:0]  out_exp,        // common exponent (larger one)
    output logic [MANT_W:0]   out_mant_big,   // {hidden,frac}, unshifted
    output logic [MANT_W:0]   out_mant_small, // {hidden,frac} >> diff
    output logic              out_sticky,     // OR of bits shifted out
    output logic              out_swapped,    // B was the larger operand
    output logic              out_eff_sub     // signs differ
);

    localparam int MW1 = MANT_W + 1;

    // stage 1 (compare) registers
    logic              s1_valid;
    logic              s1_sign_big;
    logic              s1_sign_small;
    logic [EXP_W-1:0]  s1_exp_big;
    logic [MANT_W:0]   s1_mant_big;
    logic [MANT_W:0]   s1_mant_small;
    logic [EXP_W-1:0]  s1_diff;
    logic              s1_swapped;
    logic              s1_eff_sub;

    logic              s2_valid;

    // handshake
    logic              s2_en;
    logic              s1_en;
    logic              accept;

    // stage 1 combinational
    logic [MANT_W:0]   ext_a;
    logic [MANT_W:0]   ext_b;
    logic              a_big;
    logic [EXP_W-1:0]  diff_in;

    // stage 2 combinational
    logic [MANT_W:0]   lost_mask;
    logic [MANT_W:0]   shifted;
    logic              sticky;

    // s2 can take a new entry when empty or when its current one leaves this cycle;
    // s1 can take a new pair when empty or when it moves into s2.
    assign s2_en     = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_en;
    assign s1_en     = in_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // A zero exponent encodes zero: the hidden bit and the fraction are both dropped.
    always_comb begin
        ext_a   = '0;
        ext_b   = '0;
        if (in_exp_a != '0) begin
            ext_a = {1'b1, in_mant_a};
        end
        if (in_exp_b != '0) begin
            ext_b = {1'b1, in_mant_b};
        end
        // ties go to A so equal operands never report a swap
        a_big   = (in_exp_a > in_exp_b) ||
                  ((in_exp_a == in_exp_b) && (in_mant_a >= in_mant_b));
        diff_in = a_big ? (in_exp_a - in_exp_b) : (in_exp_b - in_exp_a);
    end

    // Shift-out of the small mantissa. Once diff covers the whole {hidden,frac}
    // field every bit is lost, so sticky collapses to an OR of the full field.
    always_comb begin
        lost_mask = '0;
        shifted   = '0;
        sticky    = 1'b0;
        if (int'(s1_diff) > MW1) begin
            shifted = '0;
            sticky  = |s1_mant_small;
        end else begin
            lost_mask = ~({MW1{1'b1}} << s1_diff);
            shifted   = s1_mant_small >> s1_diff;
            sticky    = |(s1_mant_small & lost_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_sign_big    <= 1'b0;
            s1_sign_small  <= 1'b0;
            s1_exp_big     <= '0;
            s1_mant_big    <= '0;
            s1_mant_small  <= '0;
            s1_diff        <= '0;
            s1_swapped     <= 1'b0;
            s1_eff_sub     <= 1'b0;
            s2_valid       <= 1'b0;
            out_sign_big   <= 1'b0;
            out_sign_small <= 1'b0;
            out_exp        <= '0;
            out_mant_big   <= '0;
            out_mant_small <= '0;
            out_sticky     <= 1'b0;
            out_swapped    <= 1'b0;
            out_eff_sub    <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (accept) begin
                    s1_sign_big   <= a_big ? in_sign_a : in_sign_b;
                    s1_sign_small <= a_big ? in_sign_b : in_sign_a;
                    s1_exp_big    <= a_big ? in_exp_a  : in_exp_b;
                    s1_mant_big   <= a_big ? ext_a     : ext_b;
                    s1_mant_small <= a_big ? ext_b     : ext_a;
                    s1_diff       <= diff_in;
                    s1_swapped    <= !a_big;
                    s1_eff_sub    <= in_sign_a ^ in_sign_b;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                // data only moves with a valid entry so a stalled or drained
                // output keeps its last value bit-stable
                if (s1_valid) begin
                    out_sign_big   <= s1_sign_big;
                    out_sign_small <= s1_sign_small;
                    out_exp        <= s1_exp_big;
                    out_mant_big   <= s1_mant_big;
                    out_mant_small <= shifted;
                    out_sticky     <= sticky;
                    out_swapped    <= s1_swapped;
                    out_eff_sub    <= s1_eff_sub;
                end
            end
        end
    end

endmodule
